// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the data-cache miss/store port: line loads as a burst
// of word reads from a fixed-latency RAM, single byte-strobed word stores.
module dcache_mem_responder #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int MEM_LAT    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    memory_valid,
  input  logic                    memory_for_store,
  input  logic [ADDR_W-1:0]       memory_addr,
  input  logic [31:0]             memory_wdata,
  input  logic [3:0]              memory_wstrb,
  output logic                    memory_ready,
  output logic [32*LINE_WORDS-1:0] memory_rline,
  output logic                    ram_en,
  output logic [3:0]              ram_we,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [31:0]             ram_wdata,
  input  logic [31:0]             ram_rdata,
  output logic [2:0]              dbg_state_o
);

  // Handshake: memory_valid is a level held until the single-cycle memory_ready
  // pulse; a request is accepted only in IDLE, and ready never fires unrequested.

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(4 * LINE_WORDS - 1));
  localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));
  localparam logic [CNT_W-1:0]  LAST_K    = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_DRAIN = 3'd2,
    S_WR       = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [MEM_LAT-1:0]    pv_q;
  logic [MEM_LAT-1:0][CNT_W-1:0] pk_q;
  logic [LINE_WORDS-1:0][31:0]   line_q;
  logic                  issue;
  logic                  last_out;

  assign issue        = (state_q == S_RD_ISSUE);
  assign last_out     = pv_q[MEM_LAT-1] && (pk_q[MEM_LAT-1] == LAST_K);
  assign memory_rline = line_q;
  assign dbg_state_o  = state_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    cnt_d        = cnt_q;
    ram_en       = 1'b0;
    ram_we       = 4'b0000;
    ram_addr     = '0;
    ram_wdata    = '0;
    memory_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (memory_valid) begin
          addr_d  = memory_addr;
          wdata_d = memory_wdata;
          wstrb_d = memory_wstrb;
          cnt_d   = '0;
          state_d = memory_for_store ? S_WR : S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        // The line is naturally aligned, so OR-ing the word offset cannot carry.
        ram_en   = 1'b1;
        ram_addr = (addr_q & LINE_MASK) | ADDR_W'({cnt_q, 2'b00});
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_K) state_d = S_RD_DRAIN;
      end
      S_RD_DRAIN: begin
        if (last_out) state_d = S_DONE;
      end
      S_WR: begin
        ram_en    = 1'b1;
        ram_we    = wstrb_q;
        ram_addr  = addr_q & WORD_MASK;
        ram_wdata = wdata_q;
        state_d   = S_DONE;
      end
      S_DONE: begin
        memory_ready = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      pv_q    <= '0;
      pk_q    <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
      // Word index rides alongside each read so returns land in the right slot.
      pv_q[0] <= issue;
      pk_q[0] <= cnt_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pk_q[i] <= pk_q[i-1];
      end
      if (pv_q[MEM_LAT-1]) line_q[pk_q[MEM_LAT-1]] <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Bench for dcache_mem_responder: two instances (4 words/lat 2, 8 words/lat 1)
// against a word-array memory model, expected queues and negedge monitors.
module tb_dcache_mem_responder;

  localparam int L0 = 4;
  localparam int M0 = 2;
  localparam int L1 = 8;
  localparam int M1 = 1;
  localparam int MW = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic             v0, st0, rdy0, en0;
  logic [31:0]      a0, wd0, ra0, rwd0, rd0;
  logic [3:0]       ws0, we0;
  logic [32*L0-1:0] rl0;
  logic [2:0]       dbg0;

  logic             v1, st1, rdy1, en1;
  logic [31:0]      a1, wd1, ra1, rwd1, rd1;
  logic [3:0]       ws1, we1;
  logic [32*L1-1:0] rl1;
  logic [2:0]       dbg1;

  dcache_mem_responder #(.ADDR_W(32), .LINE_WORDS(L0), .MEM_LAT(M0)) u0 (
    .clk(clk), .rst(rst), .memory_valid(v0), .memory_for_store(st0),
    .memory_addr(a0), .memory_wdata(wd0), .memory_wstrb(ws0),
    .memory_ready(rdy0), .memory_rline(rl0), .ram_en(en0), .ram_we(we0),
    .ram_addr(ra0), .ram_wdata(rwd0), .ram_rdata(rd0), .dbg_state_o(dbg0));

  dcache_mem_responder #(.ADDR_W(32), .LINE_WORDS(L1), .MEM_LAT(M1)) u1 (
    .clk(clk), .rst(rst), .memory_valid(v1), .memory_for_store(st1),
    .memory_addr(a1), .memory_wdata(wd1), .memory_wstrb(ws1),
    .memory_ready(rdy1), .memory_rline(rl1), .ram_en(en1), .ram_we(we1),
    .ram_addr(ra1), .ram_wdata(rwd1), .ram_rdata(rd1), .dbg_state_o(dbg1));

  typedef struct {
    int unsigned  cyc;
    logic [255:0] line;
    bit           chk_w;
    int unsigned  widx;
    logic [31:0]  wexp;
  } resp_t;

  typedef struct {
    int unsigned cyc;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    bit          st;
  } acc_t;

  resp_t exp_q[$];
  resp_t exp1_q[$];
  acc_t  acc_q[$];
  resp_t e0, e1;
  acc_t  c0;

  int unsigned cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  logic [31:0]  mem [MW];
  logic [31:0]  ref_mem [MW];
  bit           mem_init = 1'b0;
  logic [127:0] last_line;

  logic [M0-1:0] rdv0;
  logic [11:0]   rda0 [M0];
  logic          rdv1;
  logic [11:0]   rda1;

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: byte-strobed writes from u0, MEM_LAT-delayed reads for both ports.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < MW; i++) mem[i] <= pat(i);
      mem_init <= 1'b1;
    end else if (en0) begin
      for (int b = 0; b < 4; b++)
        if (we0[b]) mem[ra0[13:2]][8*b +: 8] <= rwd0[8*b +: 8];
    end
    rdv0[0] <= en0 && (we0 == 4'b0000);
    rda0[0] <= ra0[13:2];
    for (int i = 1; i < M0; i++) begin
      rdv0[i] <= rdv0[i-1];
      rda0[i] <= rda0[i-1];
    end
    rdv1 <= en1 && (we1 == 4'b0000);
    rda1 <= ra1[13:2];
  end

  assign rd0 = rdv0[M0-1] ? mem[rda0[M0-1]] : 32'hDEAD_0BAD;
  assign rd1 = rdv1 ? mem[rda1] : 32'hDEAD_1BAD;

  // Monitors: responses and RAM accesses popped against the expected queues.
  always @(negedge clk) begin
    if (rdy0) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_ready0 cyc=%0d: got ready=1, want 0", cyc);
      end else begin
        e0 = exp_q.pop_front();
        if (cyc != e0.cyc || rl0 !== e0.line[127:0]) begin
          n_fail++;
          $display("FAIL resp0: got ready@%0d rline=%h, want ready@%0d rline=%h",
                   cyc, rl0, e0.cyc, e0.line[127:0]);
        end
        if (e0.chk_w) begin
          n_chk++;
          if (mem[e0.widx] !== e0.wexp) begin
            n_fail++;
            $display("FAIL store_word0 idx=%0d: got %h, want %h", e0.widx, mem[e0.widx], e0.wexp);
          end
        end
      end
    end
    if (en0) begin
      n_chk++;
      if (acc_q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_ram0 cyc=%0d: got ram_en=1 addr=%h, want idle", cyc, ra0);
      end else begin
        c0 = acc_q.pop_front();
        if (cyc != c0.cyc || ra0 !== c0.addr || we0 !== c0.we || (c0.st && rwd0 !== c0.wdata)) begin
          n_fail++;
          $display("FAIL ram_acc0: got cyc=%0d addr=%h we=%b wdata=%h, want cyc=%0d addr=%h we=%b wdata=%h",
                   cyc, ra0, we0, rwd0, c0.cyc, c0.addr, c0.we, c0.wdata);
        end
      end
    end
    if (rdy1) begin
      n_chk++;
      if (exp1_q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_ready1 cyc=%0d: got ready=1, want 0", cyc);
      end else begin
        e1 = exp1_q.pop_front();
        if (cyc != e1.cyc || rl1 !== e1.line) begin
          n_fail++;
          $display("FAIL resp1: got ready@%0d rline=%h, want ready@%0d rline=%h",
                   cyc, rl1, e1.cyc, e1.line);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Called at #1 after a clock edge; returns at #1 in the cycle after ready.
  task automatic req0(input bit st, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] ws);
    resp_t e;
    acc_t a;
    int unsigned n;
    logic [31:0] base, w;
    int t;
    n = cyc;
    v0 = 1'b1; st0 = st; a0 = addr; wd0 = wd; ws0 = ws;
    e.line = '0; e.chk_w = 1'b0; e.widx = 0; e.wexp = '0;
    if (st) begin
      a.cyc = n + 1; a.addr = {addr[31:2], 2'b00}; a.we = ws; a.wdata = wd; a.st = 1'b1;
      acc_q.push_back(a);
      w = ref_mem[addr[13:2]];
      for (int b = 0; b < 4; b++) if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
      ref_mem[addr[13:2]] = w;
      e.cyc = n + 2; e.line[127:0] = last_line;
      e.chk_w = 1'b1; e.widx = int'(addr[13:2]); e.wexp = w;
    end else begin
      base = addr - (addr % (4 * L0));
      for (int k = 0; k < L0; k++) begin
        a.cyc = n + 1 + k; a.addr = base + 32'(4 * k); a.we = 4'b0000; a.wdata = '0; a.st = 1'b0;
        acc_q.push_back(a);
        e.line[32*k +: 32] = ref_mem[int'(base[13:2]) + k];
      end
      last_line = e.line[127:0];
      e.cyc = n + L0 + M0 + 1;
    end
    exp_q.push_back(e);
    t = 0;
    do begin @(negedge clk); t++; end while (!rdy0 && t < 60);
    if (!rdy0) begin
      n_chk++; n_fail++;
      $display("FAIL timeout0: got no ready in %0d cycles, want ready", t);
    end
    tick();
    v0 = 1'b0;
  endtask

  task automatic req1(input logic [31:0] addr);
    resp_t e;
    int unsigned n;
    logic [31:0] base;
    int t;
    n = cyc;
    v1 = 1'b1; a1 = addr;
    e.line = '0; e.chk_w = 1'b0; e.widx = 0; e.wexp = '0;
    base = addr - (addr % (4 * L1));
    for (int k = 0; k < L1; k++) e.line[32*k +: 32] = ref_mem[int'(base[13:2]) + k];
    e.cyc = n + L1 + M1 + 1;
    exp1_q.push_back(e);
    t = 0;
    do begin @(negedge clk); t++; end while (!rdy1 && t < 60);
    if (!rdy1) begin
      n_chk++; n_fail++;
      $display("FAIL timeout1: got no ready in %0d cycles, want ready", t);
    end
    tick();
    v1 = 1'b0;
  endtask

  int unsigned n_a;
  logic [31:0] base_a;
  acc_t        a_a;
  int          gap;
  int          t_end;

  initial begin
    for (int i = 0; i < MW; i++) ref_mem[i] = pat(i);
    last_line = '0;
    rst = 1'b0;
    v0 = 1'b0; st0 = 1'b0; a0 = '0; wd0 = '0; ws0 = '0;
    v1 = 1'b0; st1 = 1'b0; a1 = '0; wd1 = '0; ws1 = '0;
    repeat (3) tick();
    chk("reset_ready0", 256'(rdy0), 256'(0));
    chk("reset_rline0", 256'(rl0), 256'(0));
    chk("reset_rline1", 256'(rl1), 256'(0));
    chk("reset_ram_en0", 256'(en0), 256'(0));
    chk("reset_ram_we0", 256'(we0), 256'(0));
    chk("reset_ram_addr0", 256'(ra0), 256'(0));
    chk("reset_ram_wdata0", 256'(rwd0), 256'(0));
    rst = 1'b1;
    repeat (2) tick();

    // Directed: line load, back-to-back store, strobe-less store, readback.
    req0(1'b0, 32'h0000_100C, 32'h0, 4'b0000);
    req0(1'b1, 32'h0000_2002, 32'hDEAD_BEEF, 4'b1100);
    tick();
    req0(1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0000);
    tick();
    req0(1'b0, 32'h0000_2008, 32'h0, 4'b0000);
    chk("store_upper_half", 256'(rl0[31:16]), 256'(16'hDEAD));
    tick();

    // Reset during the third cycle of a load aborts it.
    n_a = cyc;
    v0 = 1'b1; st0 = 1'b0; a0 = 32'h0000_0340;
    base_a = 32'h0000_0340;
    for (int k = 0; k < 3; k++) begin
      a_a.cyc = n_a + 1 + k; a_a.addr = base_a + 32'(4 * k);
      a_a.we = 4'b0000; a_a.wdata = '0; a_a.st = 1'b0;
      acc_q.push_back(a_a);
    end
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1; v0 = 1'b0; last_line = '0;
    chk("abort_rline_cleared", 256'(rl0), 256'(0));
    repeat (4) tick();
    chk("abort_late_rdata_ignored", 256'(rl0), 256'(0));
    req0(1'b0, 32'h0000_0344, 32'h0, 4'b0000);

    // Random mix of loads and stores, with back-to-back and gapped requests.
    for (int i = 0; i < 30; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      req0(1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'h3FFF)), $urandom,
           4'($urandom_range(0, 15)));
    end

    // Eight-word line, single-cycle latency instance.
    tick();
    req1(32'h0000_100C);
    for (int i = 0; i < 6; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      req1(32'($urandom_range(0, 32'h3FFF)));
    end

    t_end = 0;
    while ((exp_q.size() != 0 || acc_q.size() != 0 || exp1_q.size() != 0) && t_end < 50) begin
      tick();
      t_end++;
    end
    repeat (5) tick();
    chk("exp_q_drained", 256'(exp_q.size()), 256'(0));
    chk("acc_q_drained", 256'(acc_q.size()), 256'(0));
    chk("exp1_q_drained", 256'(exp1_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got no completion by %0t, want finish", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
